synaptic_update_engine: RTL and testbench

//  Next-generation synaptic core: owns the weight and gradient SRAMs and autonomously sweeps all

---
 rtl/synaptic_update_engine.sv | 206 ++++++++++++++++++++
 tb/tb_synaptic_update_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_update_engine.sv
// rtl/synaptic_update_engine.sv - weight/gradient SRAM owner sweeping one pre-neuron row set (ACC / APPLY)
// Optional define SYNUPD_SAT_EN: saturate updated weights/gradients instead of wrapping.
module synaptic_update_engine #(
  parameter int INPUT_NEURON  = 784,
  parameter int OUTPUT_NEURON = 256,
  parameter int P             = 4,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int GRAD_WIDTH    = 8,
  parameter int CNT_WIDTH     = 7,
  parameter int PROD_SHIFT    = 2,
  parameter int LR_SHIFT      = 1,
  localparam int ROWS  = OUTPUT_NEURON / P,
  localparam int DEPTH = INPUT_NEURON * ROWS,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = $clog2(INPUT_NEURON),
  localparam int GW    = $clog2(ROWS),
  localparam int MW    = (WEIGHT_WIDTH > GRAD_WIDTH) ? WEIGHT_WIDTH : GRAD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   is_pos,
  input  logic [PW-1:0]          pre_idx,
  input  logic [CNT_WIDTH-1:0]   pre_s_cnt,
  output logic [GW-1:0]          post_grp,
  input  logic [P*CNT_WIDTH-1:0] post_s_cnt,
  output logic                   busy,
  output logic                   done,
  input  logic                   host_cs,
  input  logic                   host_we,
  input  logic                   host_sel,
  input  logic [AW-1:0]          host_addr,
  input  logic [P*MW-1:0]        host_wdata,
  output logic [P*MW-1:0]        host_rdata,
  output logic                   host_rvalid
);

  localparam int W  = WEIGHT_WIDTH;
  localparam int G  = GRAD_WIDTH;
  localparam int C  = CNT_WIDTH;
  // Internal sum width holds the full delta so saturation sees the true result.
  localparam int SW = ((MW > 2*C) ? MW : 2*C) + 2;
  localparam logic signed [SW-1:0] W_MAX = signed'(SW'({1'b0, {(W-1){1'b1}}}));
  localparam logic signed [SW-1:0] G_MAX = signed'(SW'({1'b0, {(G-1){1'b1}}}));

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_FIN} state_t;

  state_t state, state_nxt;

  logic [GW-1:0]    grp;
  logic             mode_r;
  logic             is_pos_r;
  logic [PW-1:0]    pre_idx_r;
  logic [C-1:0]     pre_cnt_r;
  logic [AW-1:0]    row_addr;
  logic             last_row;
  logic             start_ok;
  logic             host_ok;
  logic             host_rd;
  logic [P*W-1:0]   w_q, w_calc, w_new, host_w_row;
  logic [P*G-1:0]   g_q, g_calc, g_new, host_g_row;

  logic [P*W-1:0]   weight_mem [DEPTH];
  logic [P*G-1:0]   grad_mem   [DEPTH];

  function automatic logic [W-1:0] fit_w(input logic signed [SW-1:0] v);
`ifdef SYNUPD_SAT_EN
    if (v > W_MAX) return W_MAX[W-1:0];
    if (v < ~W_MAX) return {1'b1, {(W-1){1'b0}}};
`endif
    return v[W-1:0];
  endfunction

  function automatic logic [G-1:0] fit_g(input logic signed [SW-1:0] v);
`ifdef SYNUPD_SAT_EN
    if (v > G_MAX) return G_MAX[G-1:0];
    if (v < ~G_MAX) return {1'b1, {(G-1){1'b0}}};
`endif
    return v[G-1:0];
  endfunction

  function automatic logic [W+G-1:0] lane_update(
    input logic signed [W-1:0] w,
    input logic signed [G-1:0] g,
    input logic [C-1:0]        post,
    input logic [C-1:0]        pre,
    input logic                apply,
    input logic                pos
  );
    logic [2*C-1:0]        delta;
    logic signed [SW-1:0]  sum;
    logic [W-1:0]          w_n;
    logic [G-1:0]          g_n;
    delta = ((2*C)'(pre) * (2*C)'(post)) >> PROD_SHIFT;
    w_n   = w;
    g_n   = g;
    if (apply) begin
      sum = SW'(w) + SW'(g >>> LR_SHIFT);
      w_n = fit_w(sum);
      g_n = '0;
    end else begin
      sum = pos ? (SW'(g) + signed'(SW'(delta))) : (SW'(g) - signed'(SW'(delta)));
      g_n = fit_g(sum);
    end
    return {w_n, g_n};
  endfunction

  function automatic logic [P*MW-1:0] widen_w(input logic [P*W-1:0] r);
    logic [P*MW-1:0] o;
    o = '0;
    for (int i = 0; i < P; i++) o[i*MW +: W] = r[i*W +: W];
    return o;
  endfunction

  function automatic logic [P*MW-1:0] widen_g(input logic [P*G-1:0] r);
    logic [P*MW-1:0] o;
    o = '0;
    for (int i = 0; i < P; i++) o[i*MW +: G] = r[i*G +: G];
    return o;
  endfunction

  assign row_addr = AW'(pre_idx_r) * AW'(ROWS) + AW'(grp);
  assign last_row = (grp == GW'(ROWS - 1));
  assign start_ok = (state == S_IDLE) && start;
  // Start has priority over the host in the same idle cycle.
  assign host_ok  = (state == S_IDLE) && host_cs && !start;
  assign host_rd  = host_ok && !host_we;
  assign post_grp = grp;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RD;
      S_RD:    state_nxt = S_CALC;
      S_CALC:  state_nxt = S_WR;
      S_WR:    state_nxt = last_row ? S_FIN : S_RD;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_calc     = '0;
    g_calc     = '0;
    host_w_row = '0;
    host_g_row = '0;
    for (int i = 0; i < P; i++) begin
      {w_calc[i*W +: W], g_calc[i*G +: G]} = lane_update(w_q[i*W +: W], g_q[i*G +: G],
          post_s_cnt[i*C +: C], pre_cnt_r, mode_r, is_pos_r);
      host_w_row[i*W +: W] = host_wdata[i*MW +: W];
      host_g_row[i*G +: G] = host_wdata[i*MW +: G];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grp         <= '0;
      mode_r      <= 1'b0;
      is_pos_r    <= 1'b0;
      pre_idx_r   <= '0;
      pre_cnt_r   <= '0;
      w_new       <= '0;
      g_new       <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      host_rvalid <= host_rd;
      if (start_ok) begin
        grp       <= '0;
        mode_r    <= mode;
        is_pos_r  <= is_pos;
        pre_idx_r <= pre_idx;
        pre_cnt_r <= pre_s_cnt;
      end
      if (state == S_WR && !last_row) grp <= grp + GW'(1);
      if (state == S_CALC) begin
        w_new <= w_calc;
        g_new <= g_calc;
      end
      if (host_rd)
        host_rdata <= host_sel ? widen_g(grad_mem[host_addr]) : widen_w(weight_mem[host_addr]);
    end
  end

  // SRAM arrays: no reset; writes only happen from WR or an accepted idle host write.
  always_ff @(posedge clk) begin
    if (state == S_RD) begin
      w_q <= weight_mem[row_addr];
      g_q <= grad_mem[row_addr];
    end
    if (state == S_WR) begin
      weight_mem[row_addr] <= w_new;
      grad_mem[row_addr]   <= g_new;
    end
    if (host_ok && host_we) begin
      if (host_sel) grad_mem[host_addr]   <= host_g_row;
      else          weight_mem[host_addr] <= host_w_row;
    end
  end

endmodule

// File: tb/tb_synaptic_update_engine.sv
// tb/tb_synaptic_update_engine.sv - randomized self-checking bench with a row-level reference model
module tb_synaptic_update_engine;
  localparam int P = 4, ROWS = 64, AW = 16, PW = 10, GW = 6, CW = 7;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, is_pos = 1'b0;
  logic [PW-1:0] pre_idx = '0;
  logic [CW-1:0] pre_s_cnt = '0;
  logic [GW-1:0] post_grp;
  logic [P*CW-1:0] post_s_cnt = '0;
  logic          busy, done, host_rvalid;
  logic          host_cs = 1'b0, host_we = 1'b0, host_sel = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [31:0]   host_wdata = '0, host_rdata;

  int mw[ROWS][P], mg[ROWS][P], post_tab[ROWS][P];
  int n_cmp = 0, n_err = 0;
  logic [31:0] d;

  always #5 clk = ~clk;

  synaptic_update_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .is_pos(is_pos),
    .pre_idx(pre_idx), .pre_s_cnt(pre_s_cnt), .post_grp(post_grp), .post_s_cnt(post_s_cnt),
    .busy(busy), .done(done), .host_cs(host_cs), .host_we(host_we), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid)
  );

  function automatic logic [P*CW-1:0] pack_post(input logic [GW-1:0] g);
    logic [P*CW-1:0] r;
    int v;
    for (int l = 0; l < P; l++) begin
      v = post_tab[g][l];
      r[l*CW +: CW] = v[CW-1:0];
    end
    return r;
  endfunction

  // Neuron cores answer the cycle after the group is presented.
  always @(posedge clk) post_s_cnt <= pack_post(post_grp);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int fit(input int x);
    int r;
`ifdef SYNUPD_SAT_EN
    r = (x > 127) ? 127 : (x < -128) ? -128 : x;
`else
    r = x & 255;
    if (r > 127) r -= 256;
`endif
    return r;
  endfunction

  function automatic logic [31:0] pack_row(input logic sel, input int r);
    logic [31:0] p;
    int v;
    for (int l = 0; l < P; l++) begin
      v = sel ? mg[r][l] : mw[r][l];
      p[l*8 +: 8] = v[7:0];
    end
    return p;
  endfunction

  task automatic host_write(input logic sel, input int addr, input logic [31:0] data);
    @(negedge clk);
    host_cs = 1'b1; host_we = 1'b1; host_sel = sel; host_addr = AW'(addr); host_wdata = data;
    @(negedge clk);
    host_cs = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic sel, input int addr, output logic [31:0] data);
    @(negedge clk);
    host_cs = 1'b1; host_we = 1'b0; host_sel = sel; host_addr = AW'(addr);
    @(negedge clk);
    host_cs = 1'b0;
    check("rvalid", {31'd0, host_rvalid}, 32'd1);
    data = host_rdata;
  endtask

  task automatic store_row(input int pidx, input int r);
    host_write(1'b0, pidx*ROWS + r, pack_row(1'b0, r));
    host_write(1'b1, pidx*ROWS + r, pack_row(1'b1, r));
  endtask

  task automatic load_rows(input int pidx);
    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < P; l++) begin
        mw[r][l] = int'($urandom_range(0, 255)) - 128;
        mg[r][l] = int'($urandom_range(0, 255)) - 128;
      end
      store_row(pidx, r);
    end
  endtask

  task automatic rand_post();
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < P; l++) post_tab[r][l] = int'($urandom_range(0, 127));
  endtask

  task automatic verify(input int pidx);
    logic [31:0] v;
    for (int r = 0; r < ROWS; r++) begin
      host_read(1'b0, pidx*ROWS + r, v);
      check("weight_row", v, pack_row(1'b0, r));
      host_read(1'b1, pidx*ROWS + r, v);
      check("grad_row", v, pack_row(1'b1, r));
    end
  endtask

  task automatic sweep(input logic m, input logic pos, input int pidx, input int pcnt, input int abort);
    int cycles, limit, dl;
    @(negedge clk);
    start = 1'b1; mode = m; is_pos = pos; pre_idx = PW'(pidx); pre_s_cnt = CW'(pcnt);
    host_cs = 1'b1; host_we = 1'b1; host_sel = 1'b0; host_addr = AW'(pidx*ROWS + 2);
    host_wdata = $urandom;
    @(negedge clk);
    start = 1'b0; host_cs = 1'b0; host_we = 1'b0;
    cycles = 1;
    check("busy_first", {31'd0, busy}, 32'd1);
    while (!done && cycles < 400) begin
      if (abort != 0 && cycles == abort) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
      start = (cycles == 50);
      if (cycles == 50) begin
        mode = ~m; is_pos = ~pos; pre_idx = PW'(pidx ^ 1); pre_s_cnt = ~CW'(pcnt);
      end
      host_cs = (cycles == 60 || cycles == 70);
      host_we = (cycles == 70);
      host_addr = AW'(pidx*ROWS + 1);
      host_wdata = $urandom;
      if (cycles == 61) check("rvalid_busy", {31'd0, host_rvalid}, 32'd0);
    end
    start = 1'b0; host_cs = 1'b0; host_we = 1'b0;
    if (abort == 0) begin
      check("done_latency", cycles, 193);
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd0);
      check("busy_end", {31'd0, busy}, 32'd0);
    end
    limit = (abort != 0) ? (abort - 1) / 3 : ROWS;
    for (int r = 0; r < limit; r++)
      for (int l = 0; l < P; l++) begin
        if (m) begin
          mw[r][l] = fit(mw[r][l] + (mg[r][l] >>> 1));
          mg[r][l] = 0;
        end else begin
          dl = (pcnt * post_tab[r][l]) >> 2;
          mg[r][l] = fit(mg[r][l] + (pos ? dl : -dl));
        end
      end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd0);
    check({tag, "_post_grp"}, {26'd0, post_grp}, 32'd0);
  endtask

  initial begin
    int pidx;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_rdata", host_rdata, 32'd0);
    rst_n = 1'b1;

    host_write(1'b0, 5, 32'h7F01_8010);
    host_write(1'b1, 5, 32'h1122_3344);
    host_read(1'b0, 5, d);
    check("host_w_row5", d, 32'h7F01_8010);
    host_read(1'b1, 5, d);
    check("host_g_row5", d, 32'h1122_3344);

    pidx = 3;
    load_rows(pidx);
    for (int r = 0; r < ROWS; r++) for (int l = 0; l < P; l++) post_tab[r][l] = 0;
    post_tab[0][0] = 8;
    mg[0][0] = 0;
    store_row(pidx, 0);
    sweep(1'b0, 1'b1, pidx, 4, 0);
    host_read(1'b1, pidx*ROWS, d);
    check("acc_pos_lane0", {24'd0, d[7:0]}, 32'd8);
    sweep(1'b0, 1'b0, pidx, 4, 0);
    host_read(1'b1, pidx*ROWS, d);
    check("acc_neg_lane0", {24'd0, d[7:0]}, 32'd0);
    verify(pidx);

    post_tab[0][1] = 10;
    mg[0][1] = 120;
    store_row(pidx, 0);
    sweep(1'b0, 1'b1, pidx, 8, 0);
    host_read(1'b1, pidx*ROWS, d);
`ifdef SYNUPD_SAT_EN
    check("acc_sat_lane1", {24'd0, d[15:8]}, 32'h7F);
`else
    check("acc_wrap_lane1", {24'd0, d[15:8]}, 32'h8C);
`endif

    mw[0][0] = 126;  mg[0][0] = 10;
    mw[0][1] = -128; mg[0][1] = -4;
    store_row(pidx, 0);
    sweep(1'b1, 1'b0, pidx, 0, 0);
    host_read(1'b0, pidx*ROWS, d);
`ifdef SYNUPD_SAT_EN
    check("apply_hi_lane0", {24'd0, d[7:0]}, 32'h7F);
    check("apply_lo_lane1", {24'd0, d[15:8]}, 32'h80);
`else
    check("apply_hi_lane0", {24'd0, d[7:0]}, 32'h83);
    check("apply_lo_lane1", {24'd0, d[15:8]}, 32'h7E);
`endif
    host_read(1'b1, pidx*ROWS, d);
    check("apply_grad_clr", d, 32'd0);
    verify(pidx);

    for (int it = 0; it < 4; it++) begin
      pidx = int'($urandom_range(0, 783));
      load_rows(pidx);
      rand_post();
      sweep(1'($urandom), 1'($urandom), pidx, (it == 0) ? 0 : int'($urandom_range(0, 127)), 0);
      verify(pidx);
    end

    pidx = int'($urandom_range(0, 783));
    load_rows(pidx);
    rand_post();
    sweep(1'b0, 1'b1, pidx, int'($urandom_range(1, 127)), 32);
    check_idle("post_abort");
    verify(pidx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
